uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: DEPTH, 16, number of byte entries; power of two, 2..256.
REQ-002 Parameter: ADDR_W, 4, log2(DEPTH).
REQ-003 CLK  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 rx_ready  input  1  one-cycle strobe from the receiver: rx_data valid this cycle.
REQ-006 rx_data  input  8  received byte, sampled only when rx_ready=1.
REQ-007 framing_error  input  1  one-cycle strobe from the receiver: framing error detected.
REQ-008 rd_ready  input  1  consumer accepts rd_data this cycle.
REQ-009 rd_valid  output  1  FIFO non-empty; rd_data holds the oldest byte.
REQ-010 rd_data  output  8  oldest stored byte (first-word-fall-through).
REQ-011 count  output  ADDR_W+1  number of stored bytes, 0..DEPTH.
REQ-012 full  output  1  count==DEPTH.
REQ-013 overflow  output  1  sticky: at least one byte was dropped.
REQ-014 clr_overflow  input  1  clears overflow.
REQ-015 err_count  output  8  saturating count of framing_error strobes.
REQ-016 clr_err  input  1  clears err_count.

Function
REQ-017 Push: rx_ready=1 and (full=0 or pop this cycle); write rx_data at wr_ptr; wr_ptr+1.
REQ-018 Pop: rd_valid=1 and rd_ready=1; rd_ptr+1; rd_ready is ignored while rd_valid=0.
REQ-019 Pointers are ADDR_W+1 bits and wrap modulo 2*DEPTH; count = wr_ptr - rd_ptr, truncated to ADDR_W+1 bits; memory is indexed by ptr[ADDR_W-1:0].
REQ-020 rd_valid = (count!=0); full = (count==DEPTH); both are combinational from the pointers.
REQ-021 Latency: a byte pushed in cycle N appears on rd_data with rd_valid=1 in cycle N+1 if the FIFO was empty.
REQ-022 rd_data = mem[rd_ptr]; when empty it holds the last-read or stale value (don't care).
REQ-023 Full with simultaneous pop and push: both execute; count stays DEPTH.
REQ-024 Full, rx_ready=1, no pop: byte dropped, pointers unchanged, overflow<=1 next cycle.
REQ-025 Empty with simultaneous push and rd_ready=1: push only; count becomes 1.
REQ-026 Non-full, non-empty, simultaneous push and pop: count unchanged.
REQ-027 If clr_overflow=1 and a drop occur in the same cycle, overflow<=1 (the event wins).
REQ-028 framing_error=1: err_count+1, saturating at 255; framing_error does not touch the FIFO.
REQ-029 If clr_err=1 and framing_error=1 occur in the same cycle, err_count<=1; clr_err alone gives err_count<=0.
REQ-030 rx_ready and framing_error in the same cycle are handled independently: the byte is pushed and the error is counted.

Reset
REQ-031 When rst_n=0 at a clock edge: wr_ptr=0, rd_ptr=0, overflow=0, err_count=0; outputs become rd_valid=0, count=0, full=0.
REQ-032 Memory contents are not reset; rd_data is undefined after reset.
REQ-033 Reset in the middle of operation discards all stored bytes; the first push after rst_n rises is stored at entry 0.

Structure
REQ-034 The shared UART package (uart_pkg) holds the default DEPTH, the ADDR_W derivation, and the byte width constant (8).
REQ-035 Storage is one sub-module, uart_fifo_mem: a DEPTH x 8 register array with a synchronous write port and an asynchronous read port.
REQ-036 Pointer, flag and counter logic lives in uart_rx_fifo.

Verification
REQ-037 Reset, then push 0xA5 in cycle N -> cycle N+1: rd_valid=1, rd_data=0xA5, count=1.
REQ-038 Push 0x00..0x0F, no reads -> full=1, count=16; push 0x10 -> overflow=1, 0x10 dropped; 16 pops return 0x00..0x0F in order.
REQ-039 Full FIFO, push 0x55 while popping -> count stays 16; the 0x55 byte is read out after the 15 older bytes.
REQ-040 Empty FIFO, push 0x3C with rd_ready=1 in the same cycle -> count=1 and 0x3C is still readable next cycle.
REQ-041 Send 300 framing_error strobes -> err_count=255; clr_err together with framing_error -> err_count=1.
REQ-042 Push 5 bytes, pop 2, assert rst_n=0 for 1 cycle -> count=0, rd_valid=0, overflow=0; next push 0x77 -> rd_data=0x77.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: byte width and default receive FIFO
// geometry.
package uart_pkg;

  localparam int BYTE_W      = 8;
  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_ADDR_W = $clog2(FIFO_DEPTH);

  localparam logic [7:0] ERR_MAX = 8'hFF;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the receive FIFO: one synchronous write port,
// one asynchronous read port, contents never reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: first-word-fall-through byte queue with a
// sticky overflow flag and a saturating framing-error counter.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              rx_ready,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              framing_error,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [BYTE_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow,
  input  logic              clr_overflow,
  output logic [7:0]        err_count,
  input  logic              clr_err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            push;
  logic            pop;
  logic            drop;

  // Extra pointer bit tells full apart from empty.
  assign count    = wr_ptr - rd_ptr;
  assign rd_valid = (count != '0);
  assign full     = (count == DEPTH_C);

  assign pop  = rd_valid & rd_ready;
  assign push = rx_ready & (~full | pop);
  assign drop = rx_ready & full & ~pop;

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop)  rd_ptr <= rd_ptr + ONE;
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge CLK) begin
    if (!rst_n)            overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!rst_n)
      err_count <= '0;
    else if (clr_err)
      err_count <= {7'd0, framing_error};
    else if (framing_error && err_count != ERR_MAX)
      err_count <= err_count + 8'd1;
  end

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .CLK   (CLK),
    .we    (push),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (rx_data),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic
// checked against a queue-based model.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              CLK;
  logic              rst_n;
  logic              rx_ready;
  logic [7:0]        rx_data;
  logic              framing_error;
  logic              rd_ready;
  logic              rd_valid;
  logic [7:0]        rd_data;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              overflow;
  logic              clr_overflow;
  logic [7:0]        err_count;
  logic              clr_err;

  uart_rx_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .CLK           (CLK),
    .rst_n         (rst_n),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
    .framing_error (framing_error),
    .rd_ready      (rd_ready),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .count         (count),
    .full          (full),
    .overflow      (overflow),
    .clr_overflow  (clr_overflow),
    .err_count     (err_count),
    .clr_err       (clr_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_pass  = 0;
  int n_total = 0;

  byte unsigned q[$];
  bit           m_ovf;
  int           m_err;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle();
    rst_n         = 1'b1;
    rx_ready      = 1'b0;
    rx_data       = 8'h00;
    framing_error = 1'b0;
    rd_ready      = 1'b0;
    clr_overflow  = 1'b0;
    clr_err       = 1'b0;
  endtask

  // Update the model from the driven inputs, clock, then compare.
  task automatic tick();
    int n;
    bit p;
    n = q.size();
    p = rd_ready && (n > 0);
    if (!rst_n) begin
      q.delete();
      m_ovf = 1'b0;
      m_err = 0;
    end else begin
      if (p) void'(q.pop_front());
      if (rx_ready && (n < DEPTH || p)) q.push_back(rx_data);
      if (rx_ready && n == DEPTH && !p) m_ovf = 1'b1;
      else if (clr_overflow)            m_ovf = 1'b0;
      if (clr_err)            m_err = framing_error ? 1 : 0;
      else if (framing_error) m_err = (m_err < 255) ? m_err + 1 : 255;
    end
    @(posedge CLK);
    #1;
    check("count", 32'(count), 32'(q.size()));
    check("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("err_count", 32'(err_count), 32'(m_err));
    if (q.size() != 0) check("rd_data", 32'(rd_data), 32'(q[0]));
    idle();
  endtask

  task automatic push(input byte unsigned d, input bit rr);
    rx_ready = 1'b1;
    rx_data  = d;
    rd_ready = rr;
    tick();
  endtask

  initial begin
    idle();
    m_ovf = 1'b0;
    m_err = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();

    push(8'hA5, 1'b0);
    check("a5_data", 32'(rd_data), 32'hA5);
    check("a5_count", 32'(count), 32'd1);
    rd_ready = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    check("fill_full", 32'(full), 32'd1);
    push(8'h10, 1'b0);
    check("drop_ovf", 32'(overflow), 32'd1);
    check("drop_count", 32'(count), 32'd16);
    clr_overflow = 1'b1;
    rx_ready     = 1'b1;
    rx_data      = 8'hEE;
    tick();
    check("clr_vs_drop", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    tick();
    check("clr_ovf", 32'(overflow), 32'd0);

    push(8'h55, 1'b1);
    check("full_pp", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("last_55", 32'(rd_data), 32'h55);
      rd_ready = 1'b1;
      tick();
    end
    check("drained", 32'(rd_valid), 32'd0);

    push(8'h3C, 1'b1);
    check("empty_pp", 32'(rd_data), 32'h3C);
    rd_ready = 1'b1;
    tick();

    for (int i = 0; i < 300; i++) begin
      framing_error = 1'b1;
      tick();
    end
    check("err_sat", 32'(err_count), 32'd255);
    clr_err       = 1'b1;
    framing_error = 1'b1;
    tick();
    check("err_clr_fe", 32'(err_count), 32'd1);
    clr_err = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) push(8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 2; i++) begin
      rd_ready = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    tick();
    check("rst_count", 32'(count), 32'd0);
    push(8'h77, 1'b0);
    check("rst_77", 32'(rd_data), 32'h77);

    for (int i = 0; i < 600; i++) begin
      int bias;
      bias          = (i % 200 < 100) ? 4 : 12;
      rx_ready      = ($urandom_range(15) < 9);
      rx_data       = 8'($urandom);
      rd_ready      = ($urandom_range(15) < bias);
      framing_error = ($urandom_range(7) == 0);
      clr_overflow  = ($urandom_range(15) == 0);
      clr_err       = ($urandom_range(31) == 0);
      rst_n         = ($urandom_range(249) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
